// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: splits an instruction word into register
// fields, shift amount, opcode and funct, and extends the immediate. Handshaked
// on both sides, with an optional skid slot so out_ready comes from a flop, and
// a synchronous flush that squashes everything held.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_flush,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [31:0]       in_is,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [1:0]        in_ext_mode,
  input  logic              in_ready_dn,
  output logic              out_valid,
  output logic [5:0]        out_op,
  output logic [5:0]        out_fn,
  output logic [DATA_W-1:0] out_p1,
  output logic [4:0]        out_p2,
  output logic [4:0]        out_p3,
  output logic [4:0]        out_p4,
  output logic [DATA_W-1:0] out_im,
  output logic [DATA_W-1:0] out_pc
);

  typedef struct packed {
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [DATA_W-1:0] p1;
    logic [4:0]        p2;
    logic [4:0]        p3;
    logic [4:0]        p4;
    logic [DATA_W-1:0] im;
    logic [DATA_W-1:0] pc;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   transfer;

  // Upper mode reuses the sign-extended value shifted by 16, so bit 15 of the
  // immediate lands in bit 31 and is already replicated above it for wide DATA_W.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                   input logic [1:0]  mode);
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] res;
    sext = {{(DATA_W-16){imm[15]}}, imm};
    res  = '0;
    case (mode)
      2'b00:   res = {{(DATA_W-16){1'b0}}, imm};
      2'b01:   res = sext;
      2'b10:   res = sext << 16;
      default: res = sext << 2;
    endcase
    return res;
  endfunction

  // Decode the incoming word so it can be captured into either slot.
  always_comb begin
    in_entry    = '0;
    in_entry.op = in_is[31:26];
    in_entry.fn = in_is[5:0];
    in_entry.p1 = {{(DATA_W-5){1'b0}}, in_is[10:6]};
    in_entry.p2 = in_is[20:16];
    in_entry.p3 = in_is[25:21];
    in_entry.p4 = in_is[15:11];
    in_entry.im = extend_imm(in_is[15:0], in_ext_mode);
    in_entry.pc = in_pc;
  end

  // With a skid slot, ready is just the inverted skid flop; without one it
  // passes downstream ready straight through.
  assign out_ready = SKID ? !skid_valid : (!main_valid || in_ready_dn);
  assign accept    = in_valid && out_ready && !in_flush;
  assign transfer  = main_valid && in_ready_dn;

  // Slot occupancy: flush wins, skid drains into main first, stalled accepts go to skid.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (in_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (transfer && skid_valid) begin
        skid_valid <= 1'b0;
      end else if (accept && (transfer || !main_valid)) begin
        main_valid <= 1'b1;
      end else if (transfer) begin
        main_valid <= 1'b0;
      end
      if (accept && main_valid && !transfer) begin
        skid_valid <= 1'b1;
      end
    end
  end

  // Slot payloads follow the same routing; valid flags alone qualify them.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (transfer && skid_valid) begin
        main_q <= skid_q;
      end else if (accept && (transfer || !main_valid)) begin
        main_q <= in_entry;
      end
      if (accept && main_valid && !transfer) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_op    = main_q.op;
  assign out_fn    = main_q.fn;
  assign out_p1    = main_q.p1;
  assign out_p2    = main_q.p2;
  assign out_p3    = main_q.p3;
  assign out_p4    = main_q.p4;
  assign out_im    = main_q.im;
  assign out_pc    = main_q.pc;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage between fetch and register-read/execute.
- Takes a 32-bit instruction word plus its PC and splits it into register-address fields, shift amount, opcode and funct.
- Extends the 16-bit immediate to DATA_W in one of four modes.
- Valid/ready on both sides, an optional skid entry so upstream ready is a registered signal, and a synchronous flush for branch/exception squash.

Parameters:
- DATA_W, 32, width of out_p1, out_im, in_pc and out_pc; legal values are 32 or greater.
- SKID, 1: 1 adds a second buffered entry so out_ready is taken directly from a flop; 0 gives a single stage with combinational out_ready.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream holds a valid instruction.
- out_ready  output  1  stage can accept an instruction this cycle.
- in_is  input  32  instruction word.
- in_pc  input  DATA_W  PC of the instruction.
- in_ext_mode  input  2  immediate mode: 00 zero, 01 sign, 10 upper, 11 byte-offset.
- in_ready_dn  input  1  downstream accepts out_* this cycle.
- out_valid  output  1  out_* fields are valid.
- out_op  output  6  in_is[31:26].
- out_fn  output  6  in_is[5:0].
- out_p1  output  DATA_W  shift amount in_is[10:6], zero-extended.
- out_p2  output  5  in_is[20:16] (rt).
- out_p3  output  5  in_is[25:21] (rs).
- out_p4  output  5  in_is[15:11] (rd).
- out_im  output  DATA_W  extended immediate.
- out_pc  output  DATA_W  PC of the presented instruction.

Behaviour:
- Reset (asynchronous, in_rst_n low): out_valid=0 and skid entry invalid. All data outputs are 0.
- Reset state of out_ready: 1 for SKID=1; 1 for SKID=0.
- Extension happens at capture time, from the in_ext_mode value sampled with in_is:
  - 00: zero-extend imm[15:0].
  - 01: sign-extend imm[15:0].
  - 10: imm<<16, low bits 0, then sign-extend bit 31 up to DATA_W.
  - 11: sign-extend imm, then shift left by 2.
- Accept: in_valid && out_ready at a rising edge. Latency is 1 cycle; the decoded fields appear with out_valid the next cycle.
- Transfer: out_valid && in_ready_dn. Output is held stable while out_valid && !in_ready_dn.
- SKID=0:
  - out_ready = !out_valid || in_ready_dn.
  - Simultaneous accept and transfer loads the new instruction, with no bubble.
- SKID=1, two slots: main (drives out_*) and skid.
  - out_ready = !skid_valid, registered.
  - Accept while main is empty, or main is transferring, fills main.
  - Accept while main is valid and stalled fills skid.
  - On transfer with skid valid, skid moves to main and skid is cleared.
  - Order is strictly FIFO. Full occurs when both slots are valid; out_ready=0 in that state.
  - Full throughput: 1 instr/cycle when in_ready_dn is held high.
- Flush (in_flush=1 at an edge):
  - out_valid and skid_valid are cleared.
  - Any input presented that cycle is dropped and not accepted.
  - out_ready is 1 the following cycle.
  - Flush overrides accept and transfer. The downstream must not count a transfer on the flush cycle (out_valid is still 1 combinationally, and in_ready_dn is ignored by this block).
- Reset mid-stream discards all entries immediately, without waiting for the clock.
- Data registers need not be cleared on flush; out_valid alone qualifies the data.

Test Plan:
- Reset check: hold in_rst_n=0 mid-stream with main and skid valid -> out_valid=0 and out_ready=1 immediately, with no clock edge needed.
- Sign mode: in_is=0x8CA2FFFC, mode 01, in_pc=0x00400010, in_ready_dn=1 -> next cycle:
  - out_valid=1, out_op=0x23, out_p3=5, out_p2=2.
  - out_im=0xFFFFFFFC, out_pc=0x00400010.
- Same word, other modes:
  - mode 00 -> out_im=0x0000FFFC.
  - mode 10 -> out_im=0xFFFC0000.
  - mode 11 -> out_im=0xFFFFFFF0.
- R-type: in_is=0x00054880 -> out_op=0, out_p3=0, out_p2=5, out_p4=9, out_p1=2, out_fn=0.
- Backpressure (SKID=1):
  - Stream A,B,C with in_ready_dn=0 -> A held on out_*, B stored in skid, out_ready=0, C not accepted.
  - Then raise in_ready_dn -> order A,B,C with no loss or duplication.
- Flush with both slots full:
  - Assert in_flush for 1 cycle while in_valid=1 with D -> out_valid=0 next cycle and D dropped.
  - out_ready=1 after the flush, and E then decodes normally.
- Regression sweeps:
  - SKID=0 with in_ready_dn toggling 1010… -> out_ready follows !out_valid||in_ready_dn, with no drops.
  - DATA_W=64, mode 01 on imm=0x8000 -> out_im=0xFFFFFFFFFFFF8000.
